clk_edge_monitor: RTL and testbench

- Fast-domain consumer of a slow, divider-generated clock-like signal.
- Synchronises `slow_in` into `clk`, emits single-cycle rise/fall enable ticks and measures the rising-edge period in `clk` cycles.
- Declares lock when the measured period matches the expected divide ratio, and flags loss of the slow clock.
- Sits downstream of the clock divider, so logic can stay on one clock and use the ticks as clock enables.

---
 rtl/clk_edge_monitor.sv | 115 +++++++++++
 tb/tb_clk_edge_monitor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_edge_monitor.sv
// Synchronises a slow divider-generated clock into clk, emits rise/fall enable ticks,
// measures the rise-to-rise period and tracks frequency lock and loss of the slow clock.
module clk_edge_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 32,
  parameter int TOL        = 1,
  parameter int LOCK_N     = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             slow_in,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

  localparam int MW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_THR  = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] meas;
  logic [31:0]      meas_w;
  logic [MW-1:0]    match;
  logic [MW-1:0]    match_inc;
  logic             period_ok;

  assign rise_tick = s2 & ~s3;
  assign fall_tick = ~s2 & s3;

  // Measured period is cnt+1 because cnt restarts at zero in the cycle after a tick.
  assign meas      = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
  assign meas_w    = 32'(meas);
  assign period_ok = (meas_w + 32'(TOL) >= 32'(EXP_PERIOD)) &&
                     (meas_w <= 32'(EXP_PERIOD + TOL));
  assign match_inc = (match >= MW'(LOCK_N)) ? MW'(LOCK_N) : match + MW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      cnt          <= '0;
      match        <= '0;
      state        <= IDLE;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      err_count    <= '0;
    end else begin
      s1           <= slow_in;
      s2           <= s1;
      s3           <= s2;
      period_valid <= 1'b0;
      if (!en) begin
        state  <= IDLE;
        locked <= 1'b0;
        cnt    <= '0;
        match  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise_tick) begin
              state <= ARMED;
              cnt   <= '0;
              match <= '0;
            end
          end
          default: begin
            if (rise_tick) begin
              cnt          <= '0;
              period       <= meas;
              period_valid <= 1'b1;
              timeout      <= 1'b0;
              if (period_ok) begin
                match <= match_inc;
                if (match_inc == MW'(LOCK_N)) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                match  <= '0;
                state  <= ARMED;
                locked <= 1'b0;
                if (state == LOCKED && err_count != 8'hFF)
                  err_count <= err_count + 8'd1;
              end
            end else if (cnt == TO_THR) begin
              // Loss of the slow clock: drop back and wait for a fresh arming edge.
              timeout <= 1'b1;
              state   <= IDLE;
              locked  <= 1'b0;
              match   <= '0;
              cnt     <= '0;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Bench for clk_edge_monitor: a default instance and a TIMEOUT=255 instance share stimulus
// and are both compared every cycle against an elapsed-time model.
module tb_clk_edge_monitor;

  localparam int EXP = 32;
  localparam int TOLV = 1;
  localparam int LN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic slow_in = 1'b0;

  logic       d_rise[2];
  logic       d_fall[2];
  logic [7:0] d_period[2];
  logic       d_pv[2];
  logic       d_lock[2];
  logic       d_to[2];
  logic [7:0] d_err[2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clk_edge_monitor #(.CNT_W(8), .EXP_PERIOD(EXP), .TOL(TOLV), .LOCK_N(LN), .TIMEOUT(64)) u0 (
    .clk(clk), .rst(rst), .en(en), .slow_in(slow_in),
    .rise_tick(d_rise[0]), .fall_tick(d_fall[0]), .period(d_period[0]),
    .period_valid(d_pv[0]), .locked(d_lock[0]), .timeout(d_to[0]), .err_count(d_err[0])
  );

  clk_edge_monitor #(.CNT_W(8), .EXP_PERIOD(EXP), .TOL(TOLV), .LOCK_N(LN), .TIMEOUT(255)) u1 (
    .clk(clk), .rst(rst), .en(en), .slow_in(slow_in),
    .rise_tick(d_rise[1]), .fall_tick(d_fall[1]), .period(d_period[1]),
    .period_valid(d_pv[1]), .locked(d_lock[1]), .timeout(d_to[1]), .err_count(d_err[1])
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[u%0d] @%0t: got %0h expected %0h", nm, idx, $time, act, exp);
    end
  endtask

  // Model: slow_in sample history plus, per instance, the cycle of the last counted rise.
  int  to_p[2] = '{64, 255};
  bit  h0, h1, h2;
  bit  started = 1'b0;
  int  cyc = 0;
  bit  m_active[2];
  bit  m_lock[2];
  int  m_nm[2];
  int  m_last[2];
  int  m_period[2];
  bit  m_pv[2];
  bit  m_to[2];
  int  m_err[2];

  always @(posedge clk) begin
    bit rise;
    int el;
    int d;
    started = 1'b1;
    rise = h1 & ~h2;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_active[i] = 0; m_lock[i] = 0; m_nm[i] = 0; m_last[i] = 0;
        m_period[i] = 0; m_pv[i] = 0; m_to[i] = 0; m_err[i] = 0;
      end else begin
        m_pv[i] = 0;
        el = cyc - m_last[i];
        if (!en) begin
          m_active[i] = 0; m_lock[i] = 0; m_nm[i] = 0;
        end else if (!m_active[i]) begin
          if (rise) begin
            m_active[i] = 1; m_last[i] = cyc; m_nm[i] = 0;
          end
        end else if (rise) begin
          m_period[i] = (el > 255) ? 255 : el;
          m_last[i] = cyc;
          m_pv[i] = 1;
          m_to[i] = 0;
          d = m_period[i] - EXP;
          if (d < 0) d = -d;
          if (d <= TOLV) begin
            m_nm[i] = (m_nm[i] + 1 > LN) ? LN : m_nm[i] + 1;
            if (m_nm[i] == LN) m_lock[i] = 1;
          end else begin
            if (m_lock[i] && m_err[i] < 255) m_err[i]++;
            m_lock[i] = 0;
            m_nm[i] = 0;
          end
        end else if (el == to_p[i]) begin
          m_to[i] = 1; m_active[i] = 0; m_lock[i] = 0; m_nm[i] = 0;
        end
      end
    end
    if (rst) begin
      h0 = 0; h1 = 0; h2 = 0;
    end else begin
      h2 = h1; h1 = h0; h0 = slow_in;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk("rise_tick", i, 32'(d_rise[i]), 32'(h1 & ~h2));
        chk("fall_tick", i, 32'(d_fall[i]), 32'(~h1 & h2));
        chk("period", i, 32'(d_period[i]), 32'(m_period[i]));
        chk("period_valid", i, 32'(d_pv[i]), 32'(m_pv[i]));
        chk("locked", i, 32'(d_lock[i]), 32'(m_lock[i]));
        chk("timeout", i, 32'(d_to[i]), 32'(m_to[i]));
        chk("err_count", i, 32'(d_err[i]), 32'(m_err[i]));
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sq(input int hi, input int lo);
    slow_in = 1'b1;
    wait_n(hi);
    slow_in = 1'b0;
    wait_n(lo);
  endtask

  initial begin
    wait_n(3);
    chk("lit_reset_locked", 0, 32'(d_lock[0]), 32'd0);
    chk("lit_reset_period", 0, 32'(d_period[0]), 32'd0);
    chk("lit_reset_rise", 0, 32'(d_rise[0]), 32'd0);
    rst = 1'b0;
    wait_n(2);

    // First rise: tick only in the cycle between E1 and E2.
    slow_in = 1'b1;
    wait_n(1); chk("lit_lat_e0", 0, 32'(d_rise[0]), 32'd0);
    wait_n(1); chk("lit_lat_e1", 0, 32'(d_rise[0]), 32'd1);
    wait_n(1); chk("lit_lat_e2", 0, 32'(d_rise[0]), 32'd0);
    chk("lit_arm_no_pv", 0, 32'(d_pv[0]), 32'd0);
    wait_n(13);
    slow_in = 1'b0;
    wait_n(16);
    // Second rise gives the first period strobe one cycle after its tick.
    slow_in = 1'b1;
    wait_n(2); chk("lit_rise2_tick", 0, 32'(d_rise[0]), 32'd1);
    wait_n(1); chk("lit_rise2_pv", 0, 32'(d_pv[0]), 32'd1);
    chk("lit_rise2_period", 0, 32'(d_period[0]), 32'd32);
    wait_n(13);
    slow_in = 1'b0;
    wait_n(16);
    repeat (3) sq(16, 16);
    chk("lit_lock", 0, 32'(d_lock[0]), 32'd1);
    chk("lit_lock_err", 0, 32'(d_err[0]), 32'd0);

    // Tolerance: 31 and 33 hold lock, 40 breaks it.
    sq(16, 15);
    sq(16, 17);
    sq(16, 16);
    chk("lit_tol_locked", 0, 32'(d_lock[0]), 32'd1);
    sq(16, 24);
    slow_in = 1'b1;
    wait_n(4);
    chk("lit_p40_locked", 0, 32'(d_lock[0]), 32'd0);
    chk("lit_p40_err", 0, 32'(d_err[0]), 32'd1);
    chk("lit_p40_period", 0, 32'(d_period[0]), 32'd40);
    wait_n(12);
    slow_in = 1'b0;
    wait_n(16);
    repeat (4) sq(16, 16);
    chk("lit_relock", 0, 32'(d_lock[0]), 32'd1);

    // Stop toggling: last tick registered at E2 of the final rise.
    wait_n(34);
    chk("lit_to_before", 0, 32'(d_to[0]), 32'd0);
    wait_n(1);
    chk("lit_to_set", 0, 32'(d_to[0]), 32'd1);
    chk("lit_to_unlock", 0, 32'(d_lock[0]), 32'd0);
    chk("lit_to255_locked", 1, 32'(d_lock[1]), 32'd1);
    wait_n(190);
    chk("lit_to255_before", 1, 32'(d_to[1]), 32'd0);
    wait_n(1);
    chk("lit_to255_set", 1, 32'(d_to[1]), 32'd1);

    // Re-arm keeps timeout, next rise clears it.
    sq(16, 16);
    chk("lit_rearm_to", 0, 32'(d_to[0]), 32'd1);
    sq(16, 16);
    chk("lit_rearm_clear", 0, 32'(d_to[0]), 32'd0);
    repeat (3) sq(16, 16);
    chk("lit_lock3", 0, 32'(d_lock[0]), 32'd1);

    // Enable low for 10 cycles.
    slow_in = 1'b1;
    wait_n(4);
    en = 1'b0;
    wait_n(10);
    chk("lit_en_locked", 0, 32'(d_lock[0]), 32'd0);
    chk("lit_en_period", 0, 32'(d_period[0]), 32'd32);
    en = 1'b1;
    wait_n(2);
    slow_in = 1'b0;
    wait_n(16);
    repeat (4) sq(16, 16);
    chk("lit_en_relock_early", 0, 32'(d_lock[0]), 32'd0);
    sq(16, 16);
    chk("lit_en_relock", 0, 32'(d_lock[0]), 32'd1);

    // Reset mid-period while locked.
    slow_in = 1'b1;
    wait_n(8);
    rst = 1'b1;
    wait_n(1);
    chk("lit_rst_locked", 0, 32'(d_lock[0]), 32'd0);
    chk("lit_rst_err", 0, 32'(d_err[0]), 32'd0);
    chk("lit_rst_period", 0, 32'(d_period[0]), 32'd0);
    chk("lit_rst_to", 0, 32'(d_to[0]), 32'd0);
    rst = 1'b0;
    wait_n(8);
    slow_in = 1'b0;
    wait_n(16);

    // Tick coincident with the timeout threshold: the tick wins.
    sq(16, 16);
    sq(16, 48);
    sq(16, 16);
    chk("lit_tie_to", 0, 32'(d_to[0]), 32'd0);
    chk("lit_tie_period", 0, 32'(d_period[0]), 32'd64);
    wait_n(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
